tmds_encoder: RTL

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_pkg.sv | 30 +++
 rtl/tmds_encoder.sv | 94 +++++++++
 2 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS 8b/10b definitions: control tokens and the byte popcount used
// by every channel encoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_TOKEN_00;
            2'b01:   t = CTRL_TOKEN_01;
            2'b10:   t = CTRL_TOKEN_10;
            default: t = CTRL_TOKEN_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder for one channel: transition minimisation in
// stage 1, DC balancing with a running disparity counter in stage 2.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic       ref_clk_i,
    input  logic       rst_n,
    input  logic       de_i,
    input  logic [7:0] dat_i,
    input  logic [1:0] ctrl_i,
    output logic [9:0] dat_o
);

    logic [3:0]        n1d_p0;
    logic              use_xnor_p0;
    logic [8:0]        qm_p0;

    logic              de_p1;
    logic [1:0]        ctrl_p1;
    logic [8:0]        qm_p1;

    logic [3:0]        n1_p1;
    logic [3:0]        n0_p1;
    logic signed [4:0] bal_p1;
    logic signed [4:0] two_q8_p1;
    logic [9:0]        dat_nxt_p1;
    logic signed [4:0] cnt_nxt_p1;

    logic [9:0]        dat_p2;
    logic signed [4:0] cnt_p2;

    // Stage 0 -> 1: transition-minimised q_m
    always_comb begin
        logic acc;
        n1d_p0      = popcount8(dat_i);
        use_xnor_p0 = (n1d_p0 > 4'd4) || ((n1d_p0 == 4'd4) && !dat_i[0]);
        qm_p0       = '0;
        acc         = dat_i[0];
        qm_p0[0]    = acc;
        for (int i = 1; i < 8; i++) begin
            acc      = use_xnor_p0 ? ~(acc ^ dat_i[i]) : (acc ^ dat_i[i]);
            qm_p0[i] = acc;
        end
        qm_p0[8] = ~use_xnor_p0;
    end

    always_ff @(posedge ref_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            de_p1   <= 1'b0;
            ctrl_p1 <= 2'b00;
            qm_p1   <= '0;
        end else begin
            de_p1   <= de_i;
            ctrl_p1 <= ctrl_i;
            qm_p1   <= qm_p0;
        end
    end

    // Stage 1 -> 2: DC balance; bal_p1 is N1-N0 of q_m[7:0], range -8..+8
    always_comb begin
        n1_p1      = popcount8(qm_p1[7:0]);
        n0_p1      = 4'd8 - n1_p1;
        bal_p1     = $signed({1'b0, n1_p1}) - $signed({1'b0, n0_p1});
        two_q8_p1  = qm_p1[8] ? 5'sd2 : 5'sd0;
        dat_nxt_p1 = ctrl_token(ctrl_p1);
        cnt_nxt_p1 = 5'sd0;
        if (de_p1) begin
            if ((cnt_p2 == 5'sd0) || (n1_p1 == n0_p1)) begin
                dat_nxt_p1 = {~qm_p1[8], qm_p1[8], qm_p1[8] ? qm_p1[7:0] : ~qm_p1[7:0]};
                cnt_nxt_p1 = qm_p1[8] ? (cnt_p2 + bal_p1) : (cnt_p2 - bal_p1);
            end else if (((cnt_p2 > 5'sd0) && (n1_p1 > n0_p1)) ||
                         ((cnt_p2 < 5'sd0) && (n0_p1 > n1_p1))) begin
                dat_nxt_p1 = {1'b1, qm_p1[8], ~qm_p1[7:0]};
                cnt_nxt_p1 = cnt_p2 + two_q8_p1 - bal_p1;
            end else begin
                dat_nxt_p1 = {1'b0, qm_p1[8], qm_p1[7:0]};
                cnt_nxt_p1 = cnt_p2 - (5'sd2 - two_q8_p1) + bal_p1;
            end
        end
    end

    always_ff @(posedge ref_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dat_p2 <= CTRL_TOKEN_00;
            cnt_p2 <= 5'sd0;
        end else begin
            dat_p2 <= dat_nxt_p1;
            cnt_p2 <= cnt_nxt_p1;
        end
    end

    assign dat_o = dat_p2;

endmodule
